serial_word_collector: RTL and testbench

Downstream stage of the bidirectional shift register: samples its serial output one bit per qualified clock and assembles WIDTH-bit words, honouring the shift direction in force at the start of each frame. Completed words go to a single-entry output register with a valid/ready handshake. Overrun is flagged explicitly rather than silently corrupting data. Sits between the shift-register chain and any parallel consumer (display, compare logic, FIFO).

---
 rtl/serial_word_collector_pkg.sv | 14 +
 rtl/serial_word_collector_if.sv | 26 ++
 rtl/serial_word_outreg.sv | 45 ++++
 rtl/serial_word_collector.sv | 127 ++++++++++++
 tb/tb_serial_word_collector.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for serial_word_collector: assembly FSM state encoding
// and the shift-direction constants sampled at the start of each frame.
package serial_word_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b1;
    localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out bundle of serial_word_collector. master = producer and
// consumer side (bench or surrounding logic), slave = the collector itself.
interface serial_word_collector_if #(
    parameter int WIDTH = 4
);
    logic             bit_in;
    logic             bit_en;
    logic             dir;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    modport master (
        output bit_in, bit_en, dir, flush, word_ready,
        input  word_out, word_valid, overrun, parity_err, busy
    );

    modport slave (
        input  bit_in, bit_en, dir, flush, word_ready,
        output word_out, word_valid, overrun, parity_err, busy
    );
endinterface

// File: rtl/serial_word_outreg.sv
// Single-entry valid/ready holding register for completed words; a word that
// arrives while the held one is neither free nor being taken is dropped and flagged.
module serial_word_outreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load_perr,
    input  logic             ready,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             perr,
    output logic             overrun
);

    logic slot_free;

    // The slot can take a new word if empty or if the held word leaves this cycle.
    assign slot_free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (slot_free) begin
                    word  <= load_word;
                    perr  <= load_perr;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Assembles WIDTH-bit words from a qualified serial stream, direction latched per
// frame. Define SERIAL_COLLECTOR_PARITY_EN to append an even-parity bit to each frame.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_word_collector_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             frame_dir;
    logic             busy_q;

    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             take;
    logic             last_data;
    logic             complete;
    logic [WIDTH-1:0] complete_word;
    logic             complete_perr;

    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_perr;
    logic             out_overrun;

    // The first bit of a frame uses the live dir; later bits use the latched one.
    always_comb begin
        eff_dir = (state == ST_IDLE) ? bus.dir : frame_dir;
        if (eff_dir == DIR_LSB_FIRST) begin
            shifted = {bus.bit_in, shreg[WIDTH-1:1]};
        end else begin
            shifted = {shreg[WIDTH-2:0], bus.bit_in};
        end
    end

    assign take      = bus.bit_en && !bus.flush;
    assign last_data = (state == ST_COLLECT) && (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_COLLECTOR_PARITY_EN
    assign complete      = take && (state == ST_PARITY);
    assign complete_word = shreg;
    assign complete_perr = ^{shreg, bus.bit_in};
`else
    assign complete      = take && last_data;
    assign complete_word = shifted;
    assign complete_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            frame_dir <= DIR_LSB_FIRST;
            busy_q    <= 1'b0;
        end else if (bus.flush) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (bus.bit_en) begin
            case (state)
                ST_IDLE: begin
                    frame_dir <= bus.dir;
                    shreg     <= shifted;
                    cnt       <= CNT_W'(1);
                    state     <= ST_COLLECT;
                    busy_q    <= 1'b1;
                end
                ST_COLLECT: begin
                    shreg <= shifted;
                    if (last_data) begin
                        cnt <= '0;
`ifdef SERIAL_COLLECTOR_PARITY_EN
                        state  <= ST_PARITY;
                        busy_q <= 1'b1;
`else
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    cnt    <= '0;
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    cnt    <= '0;
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    serial_word_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_word (complete_word),
        .load_perr (complete_perr),
        .ready     (bus.word_ready),
        .word      (out_word),
        .valid     (out_valid),
        .perr      (out_perr),
        .overrun   (out_overrun)
    );

    assign bus.word_out   = out_word;
    assign bus.word_valid = out_valid;
    assign bus.parity_err = out_perr;
    assign bus.overrun    = out_overrun;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector (WIDTH=4): directed frames push
// expected words; a negedge monitor pops and compares each newly presented word.
module tb_serial_word_collector;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_word_collector_if #(.WIDTH(WIDTH)) bus ();

    serial_word_collector #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ovr_seen    = 0;
    exp_t exp_q[$];
    logic prev_valid  = 1'b0;
    logic prev_acc    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: a word is newly presented when valid rises or stays high right after an accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_acc   <= 1'b0;
        end else begin
            if (bus.word_valid && (!prev_valid || prev_acc)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {28'd0, bus.word_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_out", {28'd0, bus.word_out}, {28'd0, e.word});
                    check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
                end
            end
            if (bus.overrun) ovr_seen <= ovr_seen + 1;
            prev_valid <= bus.word_valid;
            prev_acc   <= bus.word_valid && bus.word_ready;
        end
    end

    task automatic send_bit(input logic b, input logic d);
        bus.bit_in = b;
        bus.dir    = d;
        bus.bit_en = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
    endtask

    // seq[3] goes out first; toggle_at flips dir from that bit index on.
    task automatic send_frame(input logic [3:0] seq, input logic d, input int toggle_at,
                              input logic rdy_last);
        logic dd;
        for (int i = 0; i < 4; i++) begin
            dd = (toggle_at >= 0 && i >= toggle_at) ? ~d : d;
`ifndef SERIAL_COLLECTOR_PARITY_EN
            if (i == 3 && rdy_last) bus.word_ready = 1'b1;
`endif
            send_bit(seq[3-i], dd);
        end
`ifdef SERIAL_COLLECTOR_PARITY_EN
        if (rdy_last) bus.word_ready = 1'b1;
        send_bit(^seq, d);
`endif
    endtask

    task automatic push(input logic [WIDTH-1:0] w, input logic p);
        exp_t e;
        e.word = w;
        e.perr = p;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int ovr_base;

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_en     = 1'b0;
        bus.dir        = 1'b1;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;
        rst_n          = 1'b0;
        idle(2);
        check("reset_word_out", {28'd0, bus.word_out}, 32'd0);
        check("reset_word_valid", {31'd0, bus.word_valid}, 32'd0);
        check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
        check("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // LSB-first: 1,0,1,1 -> 1101, valid right after the final bit edge
        push(4'b1101, 1'b0);
        send_frame(4'b1011, 1'b1, -1, 1'b0);
        check("latency_valid", {31'd0, bus.word_valid}, 32'd1);
        idle(2);

        // MSB-first, then MSB-first with dir toggled after bit 2
        push(4'b1011, 1'b0);
        send_frame(4'b1011, 1'b0, -1, 1'b0);
        idle(1);
        push(4'b1011, 1'b0);
        send_frame(4'b1011, 1'b0, 2, 1'b0);
        idle(2);

        // Back-to-back with consumer stalled: second word dropped, one overrun pulse
        bus.word_ready = 1'b0;
        ovr_base = ovr_seen;
        push(4'b1100, 1'b0);
        send_frame(4'b0011, 1'b1, -1, 1'b0);
        send_frame(4'b1001, 1'b1, -1, 1'b0);
        check("overrun_pulse", {31'd0, bus.overrun}, 32'd1);
        check("held_word", {28'd0, bus.word_out}, 32'hC);
        idle(1);
        check("overrun_clear", {31'd0, bus.overrun}, 32'd0);
        idle(2);
        check("overrun_count", ovr_seen - ovr_base, 32'd1);
        check("held_word_later", {28'd0, bus.word_out}, 32'hC);
        bus.word_ready = 1'b1;
        idle(1);
        check("drain_valid", {31'd0, bus.word_valid}, 32'd0);

        // Same pattern but the consumer takes the old word on the completion cycle
        bus.word_ready = 1'b0;
        ovr_base = ovr_seen;
        push(4'b0011, 1'b0);
        send_frame(4'b1100, 1'b1, -1, 1'b0);
        push(4'b1010, 1'b0);
        send_frame(4'b0101, 1'b1, -1, 1'b1);
        check("no_overrun", {31'd0, bus.overrun}, 32'd0);
        check("second_loaded", {28'd0, bus.word_out}, 32'hA);
        idle(2);
        check("no_overrun_count", ovr_seen - ovr_base, 32'd0);

        // Async reset mid-frame while a word is held
        bus.word_ready = 1'b0;
        push(4'b1111, 1'b0);
        send_frame(4'b1111, 1'b1, -1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_word_out", {28'd0, bus.word_out}, 32'd0);
        check("arst_word_valid", {31'd0, bus.word_valid}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        bus.word_ready = 1'b1;
        idle(1);
        push(4'b0110, 1'b0);
        send_frame(4'b0110, 1'b1, -1, 1'b0);
        idle(2);

        // Flush after 3 bits; the bit presented with flush is discarded
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        bus.flush  = 1'b1;
        bus.bit_en = 1'b1;
        bus.bit_in = 1'b1;
        @(posedge clk);
        #1;
        bus.flush  = 1'b0;
        bus.bit_en = 1'b0;
        check("busy_after_flush", {31'd0, bus.busy}, 32'd0);
        check("flush_no_word", {31'd0, bus.word_valid}, 32'd0);
        push(4'b0111, 1'b0);
        send_frame(4'b1110, 1'b1, -1, 1'b0);
        idle(2);

`ifdef SERIAL_COLLECTOR_PARITY_EN
        // Explicit parity bits: good parity, then bad parity (word still delivered)
        push(4'b1101, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        idle(1);
        push(4'b1101, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        check("bad_parity_flag", {31'd0, bus.parity_err}, 32'd1);
        idle(2);
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
